kbd_scancode_decoder: RTL and testbench
=======================================

# kbd_scancode_decoder

Converts the PS/2 set-2 byte stream from the keyboard receiver into the `kbd_ascii` / `state` pair consumed by the falling-character game core. The core samples `state == 2'b01` together with `kbd_ascii`. This block handles the following:
- break (`F0`) and extended (`E0`) prefixes
- shift and caps-lock tracking
- typematic-repeat suppression
- prefix timeouts

It sits between the PS/2 receiver and the game core, in the core's clock domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2500000. Idle cycles after a prefix byte before the prefix is abandoned (50 ms at 50 MHz).
- `CNT_W`, default 22. Width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1. System clock (the clock that drives the game core).
- `reset` in 1. One clock; reset is asynchronous and active-high.
- `ps2_ready` in 1. One-cycle strobe: `ps2_data` is valid this cycle.
- `ps2_data` in 8. Received scancode byte.
- `kbd_ascii` out 8. ASCII of the currently held key; 0 when no printable key is held.
- `state` out 2. 00 = no key held; 01 = printable key held; 10 = non-printable key held; 11 is never driven.
- `key_strobe` out 1. One-cycle pulse on each new (non-repeat) printable press.
- `shift_o` out 1. Either shift key is down.
- `caps_o` out 1. Caps-lock toggle state.

## Operation
Prefix FSM states:
- `IDLE`: `E0` → `EXT`; `F0` → `BRK`; any other byte is a make code, handled in `IDLE`.
- `EXT`: `F0` → `EXT_BRK`; any other byte is an extended make, which is mapped as non-printable; return to `IDLE`.
- `BRK`: the byte is a break code; apply it; return to `IDLE`.
- `EXT_BRK`: the byte is an extended break; apply it; return to `IDLE`.

Make code handling:
- `12` or `59` sets that side's shift bit. `shift_o` = OR of the two side bits.
- `58` toggles `caps_o`, only when it is not a repeat (i.e. `58` is not already marked held).
- Any other code is looked up in the ROM.
  - If it equals the held code: typematic repeat. No strobe, no output change.
  - Otherwise it replaces the held code.
    - Printable: `state` = 01, `kbd_ascii` = mapped value, `key_strobe` pulses.
    - Unmapped: `state` = 10, `kbd_ascii` = 0.

Break code handling:
- Shift breaks clear that side's shift bit.
- Break of `58` clears the caps-held mark only.
- Break matching the held code: `state` = 00, `kbd_ascii` = 0, held code cleared.
- Other breaks are ignored.

Mapping (ROM):
- Letters map to lowercase `61`–`7A`. Uppercase `41`–`5A` when `shift_o` XOR `caps_o`.
- Digits row maps to `30`–`39`. Shift does not alter digits.
- Space `29` → `20`; Enter `5A` → `0D`; Backspace `66` → `08`.
- Everything else is unmapped.
- Case is resolved at make time. A later shift change does not alter a held `kbd_ascii`.
- Extended codes are never printable.

Timeout:
- The counter clears on every `ps2_ready`.
- In any non-`IDLE` state, it increments each cycle.
- At `TIMEOUT_CYCLES`, the FSM returns to `IDLE` and the pending prefix is dropped. Held key, shift and caps are untouched.

## Timing
- All outputs are registered. Latency is 1 cycle: the byte accepted on edge N is reflected on outputs after edge N+1.
- `key_strobe` is high for exactly one cycle, coincident with the `state`/`kbd_ascii` update.
- `ps2_ready` back-to-back on consecutive cycles must be accepted. The FSM consumes one byte per cycle with no stall and no back-pressure.
- `ps2_ready` arriving in the same cycle as the timeout expiry: the byte wins. It is interpreted in the current (prefix) state.
- Reset values, asynchronous on `reset` assertion:
  - FSM `IDLE`; timeout counter 0; held code 0.
  - `kbd_ascii` 0; `state` 00; `key_strobe` 0; `shift_o` 0; `caps_o` 0.
- Reset mid-prefix discards the prefix. The first byte after deassertion is decoded from `IDLE`.

## Structure
- Shared package `kbd_pkg` holds:
  - FSM state enum (`IDLE`, `EXT`, `BRK`, `EXT_BRK`).
  - Scancode constants: `SC_E0`, `SC_F0`, `SC_LSHIFT` = `12`, `SC_RSHIFT` = `59`, `SC_CAPS` = `58`.
  - State codes: `ST_NONE`, `ST_PRINT`, `ST_OTHER`.
- One sub-module, `scancode_rom`. Purely combinational lookup: code plus upper-case flag in; 8-bit ASCII plus a printable flag out.

## Test plan
- Press/release 'a': `1C`, then `F0 1C` → `state` 01 with `kbd_ascii` `61`, and one `key_strobe`; then `state` 00 with `kbd_ascii` 00.
- Shift + key: `12`, `1C` → `kbd_ascii` `41`. Then `F0 12` → `kbd_ascii` stays `41` until `F0 1C` clears it to 00.
- Caps-lock toggle:
  - `58 58 58 F0 58` toggles caps once.
  - `1C` then yields `41`.
  - `12 1C` (shift + caps) yields `61`.
- Typematic and extended codes:
  - `1C 1C 1C` → exactly one `key_strobe`; `state` held at 01.
  - `E0 75` → `state` 10, `kbd_ascii` 00.
  - `E0 F0 75` → `state` 00.
- Prefix timeout: `F0`, then silence for `TIMEOUT_CYCLES` + 2 cycles, then `1C` → decoded as a make (`state` 01, `kbd_ascii` `61`), not a break.
- Reset and back-to-back bytes:
  - Assert `reset` between `F0` and `1C` → all outputs 0 immediately; a following `1C` is a make.
  - Bytes `29 F0 29` on consecutive cycles → strobe, then `state` 00 three cycles after the first byte.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 scancode decoder.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_t;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_PRINT = 2'b01;
    localparam logic [1:0] ST_OTHER = 2'b10;

endpackage

// File: rtl/kbd_scancode_decoder_rom.sv
// Combinational set-2 scancode to ASCII lookup; letters are upper-cased on request.
module scancode_rom
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       upper,
    output logic [7:0] ascii,
    output logic       printable
);

    logic [7:0] lower;

    always_comb begin
        lower     = 8'h00;
        printable = 1'b1;
        case (code)
            8'h1C: lower = 8'h61;   8'h32: lower = 8'h62;   8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;   8'h24: lower = 8'h65;   8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;   8'h33: lower = 8'h68;   8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;   8'h42: lower = 8'h6B;   8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;   8'h31: lower = 8'h6E;   8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;   8'h15: lower = 8'h71;   8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;   8'h2C: lower = 8'h74;   8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;   8'h1D: lower = 8'h77;   8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;   8'h1A: lower = 8'h7A;
            8'h45: lower = 8'h30;   8'h16: lower = 8'h31;   8'h1E: lower = 8'h32;
            8'h26: lower = 8'h33;   8'h25: lower = 8'h34;   8'h2E: lower = 8'h35;
            8'h36: lower = 8'h36;   8'h3D: lower = 8'h37;   8'h3E: lower = 8'h38;
            8'h46: lower = 8'h39;
            8'h29: lower = 8'h20;
            8'h5A: lower = 8'h0D;
            8'h66: lower = 8'h08;
            default: printable = 1'b0;
        endcase
    end

    // Only the letter range has a case; digits and controls pass through.
    always_comb begin
        ascii = lower;
        if (upper && lower >= 8'h61 && lower <= 8'h7A) begin
            ascii = lower - 8'h20;
        end
    end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// PS/2 set-2 byte stream to held-key ASCII/state for the game core.
// pstate  | meaning
// IDLE    | no prefix pending; non-prefix bytes are make codes
// EXT     | E0 seen; next non-F0 byte is an extended make
// BRK     | F0 seen; next byte is a break code
// EXT_BRK | E0 F0 seen; next byte is an extended break
module kbd_scancode_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    output logic [7:0] kbd_ascii,
    output logic [1:0] state,
    output logic       key_strobe,
    output logic       shift_o,
    output logic       caps_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic             rdy_q;
    logic [7:0]       data_q;
    kbd_state_t       pstate, pstate_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [8:0]       held, held_nxt;
    logic             shift_l, shift_r, shift_l_nxt, shift_r_nxt;
    logic             caps_held, caps_held_nxt, caps_nxt;
    logic [7:0]       ascii_nxt;
    logic [1:0]       st_nxt;
    logic             strobe_nxt;
    logic             is_make, is_break, is_ext;
    logic [8:0]       code_key;
    logic [7:0]       rom_ascii;
    logic             rom_printable;

    // Held code carries the extended flag so E0-prefixed keys never alias plain ones.
    assign code_key = {is_ext, data_q};

    scancode_rom u_rom (
        .code      (data_q),
        .upper     ((shift_l | shift_r) ^ caps_o),
        .ascii     (rom_ascii),
        .printable (rom_printable)
    );

    always_comb begin
        pstate_nxt = pstate;
        cnt_nxt    = cnt;
        is_make    = 1'b0;
        is_break   = 1'b0;
        is_ext     = 1'b0;
        if (rdy_q) begin
            cnt_nxt = '0;
            case (pstate)
                IDLE: begin
                    if (data_q == SC_E0)      pstate_nxt = EXT;
                    else if (data_q == SC_F0) pstate_nxt = BRK;
                    else                      is_make = 1'b1;
                end
                EXT: begin
                    if (data_q == SC_F0) begin
                        pstate_nxt = EXT_BRK;
                    end else begin
                        is_make    = 1'b1;
                        is_ext     = 1'b1;
                        pstate_nxt = IDLE;
                    end
                end
                BRK: begin
                    is_break   = 1'b1;
                    pstate_nxt = IDLE;
                end
                default: begin
                    is_break   = 1'b1;
                    is_ext     = 1'b1;
                    pstate_nxt = IDLE;
                end
            endcase
        end else if (pstate != IDLE) begin
            if (cnt == TIMEOUT_VAL) begin
                pstate_nxt = IDLE;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        held_nxt      = held;
        shift_l_nxt   = shift_l;
        shift_r_nxt   = shift_r;
        caps_nxt      = caps_o;
        caps_held_nxt = caps_held;
        ascii_nxt     = kbd_ascii;
        st_nxt        = state;
        strobe_nxt    = 1'b0;
        if (is_make) begin
            if (!is_ext && data_q == SC_LSHIFT) begin
                shift_l_nxt = 1'b1;
            end else if (!is_ext && data_q == SC_RSHIFT) begin
                shift_r_nxt = 1'b1;
            end else if (!is_ext && data_q == SC_CAPS) begin
                if (!caps_held) caps_nxt = ~caps_o;
                caps_held_nxt = 1'b1;
            end else if (code_key != held) begin
                held_nxt = code_key;
                if (!is_ext && rom_printable) begin
                    st_nxt     = ST_PRINT;
                    ascii_nxt  = rom_ascii;
                    strobe_nxt = 1'b1;
                end else begin
                    st_nxt    = ST_OTHER;
                    ascii_nxt = 8'h00;
                end
            end
        end
        if (is_break) begin
            if (!is_ext && data_q == SC_LSHIFT) begin
                shift_l_nxt = 1'b0;
            end else if (!is_ext && data_q == SC_RSHIFT) begin
                shift_r_nxt = 1'b0;
            end else if (!is_ext && data_q == SC_CAPS) begin
                caps_held_nxt = 1'b0;
            end else if (code_key == held) begin
                held_nxt  = '0;
                st_nxt    = ST_NONE;
                ascii_nxt = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q      <= 1'b0;
            data_q     <= 8'h00;
            pstate     <= IDLE;
            cnt        <= '0;
            held       <= '0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps_held  <= 1'b0;
            kbd_ascii  <= 8'h00;
            state      <= ST_NONE;
            key_strobe <= 1'b0;
            shift_o    <= 1'b0;
            caps_o     <= 1'b0;
        end else begin
            rdy_q      <= ps2_ready;
            data_q     <= ps2_data;
            pstate     <= pstate_nxt;
            cnt        <= cnt_nxt;
            held       <= held_nxt;
            shift_l    <= shift_l_nxt;
            shift_r    <= shift_r_nxt;
            caps_held  <= caps_held_nxt;
            kbd_ascii  <= ascii_nxt;
            state      <= st_nxt;
            key_strobe <= strobe_nxt;
            shift_o    <= shift_l_nxt | shift_r_nxt;
            caps_o     <= caps_nxt;
        end
    end

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random stream vs model.
module tb_kbd_scancode_decoder;

    localparam int T = 20;

    logic       clk;
    logic       reset;
    logic       ps2_ready;
    logic [7:0] ps2_data;
    logic [7:0] kbd_ascii;
    logic [1:0] state;
    logic       key_strobe;
    logic       shift_o;
    logic       caps_o;

    int errors = 0;
    int checks = 0;

    kbd_scancode_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_ready  (ps2_ready),
        .ps2_data   (ps2_data),
        .kbd_ascii  (kbd_ascii),
        .state      (state),
        .key_strobe (key_strobe),
        .shift_o    (shift_o),
        .caps_o     (caps_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] ascii;
        logic [1:0] st;
        logic       strobe;
        logic       shift;
        logic       caps;
    } vec_t;

    vec_t vecs[$];

    // Reference tables in alphabetical / numeric order.
    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'h76,
                              8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h1A, 8'h75};

    // Behavioural model state
    bit         m_ext, m_brk, m_sl, m_sr, m_caps, m_caps_held, m_strobe;
    int         m_held;
    logic [7:0] m_ascii;
    logic [1:0] m_state;
    int         m_idle;

    function automatic logic [12:0] dut_out();
        return {kbd_ascii, state, key_strobe, shift_o, caps_o};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ascii=%h st=%b stb=%b sh=%b caps=%b, expected ascii=%h st=%b stb=%b sh=%b caps=%b",
                     name, act[12:5], act[4:3], act[2], act[1], act[0],
                     exp[12:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic [7:0] a, input logic [1:0] s,
                       input logic k, input logic sh, input logic c);
        vec_t v;
        v.data = d; v.ascii = a; v.st = s; v.strobe = k; v.shift = sh; v.caps = c;
        vecs.push_back(v);
    endtask

    // Byte is taken on the next rising edge; outputs settle one edge later.
    task automatic send(input logic [7:0] d);
        ps2_ready = 1'b1;
        ps2_data  = d;
        @(negedge clk);
        ps2_ready = 1'b0;
        @(negedge clk);
    endtask

    function automatic int lookup(input logic [7:0] code, input bit upper);
        for (int i = 0; i < 26; i++)
            if (letter_sc[i] == code) return upper ? (8'h41 + i) : (8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (digit_sc[i] == code) return 8'h30 + i;
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        if (code == 8'h66) return 8'h08;
        return -1;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0; m_caps = 0; m_caps_held = 0;
        m_strobe = 0; m_held = -1; m_ascii = 8'h00; m_state = 2'b00; m_idle = 0;
    endtask

    task automatic model_make(input logic [7:0] b, input bit e);
        int key, a;
        key = e ? (256 + b) : b;
        if (!e && b == 8'h12) m_sl = 1;
        else if (!e && b == 8'h59) m_sr = 1;
        else if (!e && b == 8'h58) begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1;
        end else if (key != m_held) begin
            m_held = key;
            a = e ? -1 : lookup(b, (m_sl || m_sr) ^ m_caps);
            if (a >= 0) begin
                m_state = 2'b01; m_ascii = a[7:0]; m_strobe = 1;
            end else begin
                m_state = 2'b10; m_ascii = 8'h00;
            end
        end
    endtask

    task automatic model_break(input logic [7:0] b, input bit e);
        int key;
        key = e ? (256 + b) : b;
        if (!e && b == 8'h12) m_sl = 0;
        else if (!e && b == 8'h59) m_sr = 0;
        else if (!e && b == 8'h58) m_caps_held = 0;
        else if (key == m_held) begin
            m_held = -1; m_state = 2'b00; m_ascii = 8'h00;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_brk) begin
            model_break(b, m_ext);
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else begin model_make(b, 1); m_ext = 0; end
        end else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else model_make(b, 0);
        end
    endtask

    task automatic rcycle(input logic rdy, input logic [7:0] d);
        ps2_ready = rdy;
        ps2_data  = d;
        @(negedge clk);
        check("random", dut_out(), {m_ascii, m_state, m_strobe, m_sl | m_sr, m_caps});
        m_strobe = 0;
        if (rdy) begin
            if (m_idle > T + 1) begin m_ext = 0; m_brk = 0; end
            model_byte(d);
            m_idle = 0;
        end else begin
            m_idle++;
        end
    endtask

    initial begin
        reset = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00;
        #3;
        check("reset_state", dut_out(), 13'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // data, ascii, state, strobe, shift, caps
        add(8'h1C, 8'h61, 2'b01, 1, 0, 0);  add(8'hF0, 8'h61, 2'b01, 0, 0, 0);
        add(8'h1C, 8'h00, 2'b00, 0, 0, 0);
        add(8'h12, 8'h00, 2'b00, 0, 1, 0);  add(8'h1C, 8'h41, 2'b01, 1, 1, 0);
        add(8'hF0, 8'h41, 2'b01, 0, 1, 0);  add(8'h12, 8'h41, 2'b01, 0, 0, 0);
        add(8'hF0, 8'h41, 2'b01, 0, 0, 0);  add(8'h1C, 8'h00, 2'b00, 0, 0, 0);
        add(8'h58, 8'h00, 2'b00, 0, 0, 1);  add(8'h58, 8'h00, 2'b00, 0, 0, 1);
        add(8'h58, 8'h00, 2'b00, 0, 0, 1);  add(8'hF0, 8'h00, 2'b00, 0, 0, 1);
        add(8'h58, 8'h00, 2'b00, 0, 0, 1);
        add(8'h1C, 8'h41, 2'b01, 1, 0, 1);  add(8'hF0, 8'h41, 2'b01, 0, 0, 1);
        add(8'h1C, 8'h00, 2'b00, 0, 0, 1);
        add(8'h12, 8'h00, 2'b00, 0, 1, 1);  add(8'h1C, 8'h61, 2'b01, 1, 1, 1);
        add(8'h1C, 8'h61, 2'b01, 0, 1, 1);  add(8'h1C, 8'h61, 2'b01, 0, 1, 1);
        add(8'hF0, 8'h61, 2'b01, 0, 1, 1);  add(8'h12, 8'h61, 2'b01, 0, 0, 1);
        add(8'hF0, 8'h61, 2'b01, 0, 0, 1);  add(8'h1C, 8'h00, 2'b00, 0, 0, 1);
        add(8'hE0, 8'h00, 2'b00, 0, 0, 1);  add(8'h75, 8'h00, 2'b10, 0, 0, 1);
        add(8'hE0, 8'h00, 2'b10, 0, 0, 1);  add(8'hF0, 8'h00, 2'b10, 0, 0, 1);
        add(8'h75, 8'h00, 2'b00, 0, 0, 1);
        add(8'h58, 8'h00, 2'b00, 0, 0, 0);  add(8'hF0, 8'h00, 2'b00, 0, 0, 0);
        add(8'h58, 8'h00, 2'b00, 0, 0, 0);
        add(8'hE0, 8'h00, 2'b00, 0, 0, 0);  add(8'h1C, 8'h00, 2'b10, 0, 0, 0);
        add(8'h1C, 8'h61, 2'b01, 1, 0, 0);  add(8'hE0, 8'h61, 2'b01, 0, 0, 0);
        add(8'hF0, 8'h61, 2'b01, 0, 0, 0);  add(8'h1C, 8'h61, 2'b01, 0, 0, 0);
        add(8'hF0, 8'h61, 2'b01, 0, 0, 0);  add(8'h1C, 8'h00, 2'b00, 0, 0, 0);
        add(8'h12, 8'h00, 2'b00, 0, 1, 0);  add(8'h16, 8'h31, 2'b01, 1, 1, 0);
        add(8'hF0, 8'h31, 2'b01, 0, 1, 0);  add(8'h12, 8'h31, 2'b01, 0, 0, 0);
        add(8'h29, 8'h20, 2'b01, 1, 0, 0);  add(8'h5A, 8'h0D, 2'b01, 1, 0, 0);
        add(8'h66, 8'h08, 2'b01, 1, 0, 0);  add(8'h76, 8'h00, 2'b10, 0, 0, 0);
        add(8'h59, 8'h00, 2'b10, 0, 1, 0);  add(8'hF0, 8'h00, 2'b10, 0, 1, 0);
        add(8'h59, 8'h00, 2'b10, 0, 0, 0);
        add(8'h4D, 8'h70, 2'b01, 1, 0, 0);  add(8'h1A, 8'h7A, 2'b01, 1, 0, 0);
        add(8'h45, 8'h30, 2'b01, 1, 0, 0);  add(8'hF0, 8'h30, 2'b01, 0, 0, 0);
        add(8'h4D, 8'h30, 2'b01, 0, 0, 0);  add(8'hF0, 8'h30, 2'b01, 0, 0, 0);
        add(8'h45, 8'h00, 2'b00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].data);
            check($sformatf("vec%0d_%h", i, vecs[i].data), dut_out(),
                  {vecs[i].ascii, vecs[i].st, vecs[i].strobe, vecs[i].shift, vecs[i].caps});
        end

        // Abandoned break prefix: 1C after long silence is a make.
        send(8'hF0);
        repeat (T + 1) @(negedge clk);
        send(8'h1C);
        check("timeout_make", dut_out(), {8'h61, 2'b01, 1'b1, 1'b0, 1'b0});
        // Short silence keeps the prefix: 1C is a break.
        send(8'hF0);
        repeat (T - 3) @(negedge clk);
        send(8'h1C);
        check("no_timeout_break", dut_out(), {8'h00, 2'b00, 1'b0, 1'b0, 1'b0});

        // Reset mid-prefix.
        send(8'h12); send(8'h1C); send(8'h58);
        check("pre_reset", dut_out(), {8'h41, 2'b01, 1'b0, 1'b1, 1'b1});
        send(8'hF0);
        reset = 1'b1;
        #1;
        check("async_reset", dut_out(), 13'h0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h1C);
        check("after_reset_make", dut_out(), {8'h61, 2'b01, 1'b1, 1'b0, 1'b0});
        send(8'hF0); send(8'h1C);
        check("release_before_b2b", dut_out(), 13'h0);

        // Back-to-back 29 F0 29.
        ps2_ready = 1'b1; ps2_data = 8'h29;
        @(negedge clk); ps2_data = 8'hF0;
        @(negedge clk); ps2_data = 8'h29;
        check("b2b_strobe", dut_out(), {8'h20, 2'b01, 1'b1, 1'b0, 1'b0});
        @(negedge clk); ps2_ready = 1'b0;
        check("b2b_held", dut_out(), {8'h20, 2'b01, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        check("b2b_release", dut_out(), 13'h0);

        // Random stream against the model.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            int gap;
            gap = ($urandom_range(0, 11) == 0) ? (T + 20) : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) rcycle(1'b0, 8'h00);
            rcycle(1'b1, pool[$urandom_range(0, 15)]);
        end
        rcycle(1'b0, 8'h00);
        rcycle(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
